// File: rtl/depar_seg_merge.sv
// depar_seg_merge: deparser output stage.
// Pops one fst-half entry ({seg1,seg0}) and one snd-half entry ({seg3,seg2}) per packet,
// then, for packets longer than four segments, pops the remaining-segment FIFO, and
// re-serialises every segment in original order onto one registered AXI-Stream master.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   fst_* / snd_*            FWFT half-FIFO heads (two segments each), *_rd_en pops
//   rem_*                    FWFT remaining-segment FIFO head, rem_rd_en pops
//   m_axis_*                 registered output stream
//   pkt_cnt                  packets fully emitted (tlast beat accepted), wraps
module depar_seg_merge #(
  parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_NUM_SEGS         = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [2*C_AXIS_DATA_WIDTH-1:0]    fst_tdata,
  input  logic [2*C_AXIS_TUSER_WIDTH-1:0]   fst_tuser,
  input  logic [2*C_AXIS_DATA_WIDTH/8-1:0]  fst_tkeep,
  input  logic [1:0]                        fst_tlast,
  input  logic                              fst_empty,
  output logic                              fst_rd_en,
  input  logic [2*C_AXIS_DATA_WIDTH-1:0]    snd_tdata,
  input  logic [2*C_AXIS_TUSER_WIDTH-1:0]   snd_tuser,
  input  logic [2*C_AXIS_DATA_WIDTH/8-1:0]  snd_tkeep,
  input  logic [1:0]                        snd_tlast,
  input  logic                              snd_empty,
  output logic                              snd_rd_en,
  input  logic [C_AXIS_DATA_WIDTH-1:0]      rem_tdata,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]     rem_tuser,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]    rem_tkeep,
  input  logic                              rem_tlast,
  input  logic                              rem_empty,
  output logic                              rem_rd_en,
  output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [31:0]                       pkt_cnt
);

  localparam int unsigned DW = C_AXIS_DATA_WIDTH;
  localparam int unsigned UW = C_AXIS_TUSER_WIDTH;
  localparam int unsigned KW = C_AXIS_DATA_WIDTH / 8;
  localparam logic [1:0]  LastIdx = 2'(C_NUM_SEGS - 1);

  typedef enum logic [1:0] {StIdle, StEmit, StFlush} state_e;

  state_e          r_state, w_state_d;
  logic [1:0]      r_seg_idx, w_seg_idx_d;

  // Four-segment holding register, index = original segment number.
  logic [DW-1:0]   r_hold_data [4];
  logic [UW-1:0]   r_hold_user [4];
  logic [KW-1:0]   r_hold_keep [4];
  logic [3:0]      r_hold_last;

  logic            r_tvalid;
  logic [DW-1:0]   r_tdata;
  logic [UW-1:0]   r_tuser;
  logic [KW-1:0]   r_tkeep;
  logic            r_tlast;
  logic [31:0]     r_pkt_cnt;

  logic            w_slot_free;
  logic            w_half_pop;
  logic            w_rem_pop;
  logic            w_load;
  logic [DW-1:0]   w_beat_data;
  logic [UW-1:0]   w_beat_user;
  logic [KW-1:0]   w_beat_keep;
  logic            w_beat_last;

  assign w_slot_free = !r_tvalid || m_axis_tready;

  always_comb begin
    w_state_d   = r_state;
    w_seg_idx_d = r_seg_idx;
    w_half_pop  = 1'b0;
    w_rem_pop   = 1'b0;
    w_load      = 1'b0;
    w_beat_data = r_hold_data[r_seg_idx];
    w_beat_user = r_hold_user[r_seg_idx];
    w_beat_keep = r_hold_keep[r_seg_idx];
    w_beat_last = r_hold_last[r_seg_idx];
    unique case (r_state)
      StIdle: begin
        if (!fst_empty && !snd_empty) begin
          w_half_pop  = 1'b1;
          w_seg_idx_d = 2'd0;
          w_state_d   = StEmit;
        end
      end
      StEmit: begin
        if (w_slot_free) begin
          w_load = 1'b1;
          if (w_beat_last) begin
            w_state_d = StIdle;
          end else if (r_seg_idx == LastIdx) begin
            w_state_d = StFlush;
          end else begin
            w_seg_idx_d = r_seg_idx + 2'd1;
          end
        end
      end
      StFlush: begin
        if (w_slot_free && !rem_empty) begin
          w_rem_pop   = 1'b1;
          w_load      = 1'b1;
          w_beat_data = rem_tdata;
          w_beat_user = rem_tuser;
          w_beat_keep = rem_tkeep;
          w_beat_last = rem_tlast;
          if (rem_tlast) w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
    // Pops are suppressed while reset is held, whatever state we were left in.
    if (rst) begin
      w_half_pop = 1'b0;
      w_rem_pop  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_seg_idx   <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        r_hold_data[i] <= '0;
        r_hold_user[i] <= '0;
        r_hold_keep[i] <= '0;
      end
      r_hold_last <= '0;
      r_tvalid    <= 1'b0;
      r_tdata     <= '0;
      r_tuser     <= '0;
      r_tkeep     <= '0;
      r_tlast     <= 1'b0;
      r_pkt_cnt   <= '0;
    end else begin
      r_state   <= w_state_d;
      r_seg_idx <= w_seg_idx_d;
      if (w_half_pop) begin
        r_hold_data[0] <= fst_tdata[DW-1:0];
        r_hold_data[1] <= fst_tdata[2*DW-1:DW];
        r_hold_data[2] <= snd_tdata[DW-1:0];
        r_hold_data[3] <= snd_tdata[2*DW-1:DW];
        r_hold_user[0] <= fst_tuser[UW-1:0];
        r_hold_user[1] <= fst_tuser[2*UW-1:UW];
        r_hold_user[2] <= snd_tuser[UW-1:0];
        r_hold_user[3] <= snd_tuser[2*UW-1:UW];
        r_hold_keep[0] <= fst_tkeep[KW-1:0];
        r_hold_keep[1] <= fst_tkeep[2*KW-1:KW];
        r_hold_keep[2] <= snd_tkeep[KW-1:0];
        r_hold_keep[3] <= snd_tkeep[2*KW-1:KW];
        r_hold_last    <= {snd_tlast, fst_tlast};
      end
      if (w_load) begin
        r_tvalid <= 1'b1;
        r_tdata  <= w_beat_data;
        r_tuser  <= w_beat_user;
        r_tkeep  <= w_beat_keep;
        r_tlast  <= w_beat_last;
      end else if (w_slot_free) begin
        r_tvalid <= 1'b0;
      end
      if (r_tvalid && m_axis_tready && r_tlast) r_pkt_cnt <= r_pkt_cnt + 32'd1;
    end
  end

  assign fst_rd_en     = w_half_pop;
  assign snd_rd_en     = w_half_pop;
  assign rem_rd_en     = w_rem_pop;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tuser  = r_tuser;
  assign m_axis_tkeep  = r_tkeep;
  assign m_axis_tlast  = r_tlast;
  assign pkt_cnt       = r_pkt_cnt;

endmodule

// File: tb/tb_depar_seg_merge.sv
// Bench for depar_seg_merge: queue-modelled FWFT FIFOs, expected-beat scoreboard,
// a table of packet lengths plus hand sequences for stall, backpressure, reset, wrap.
module tb_depar_seg_merge;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int KW = 32;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic [KW-1:0] keep;
    logic          last;
  } seg_t;

  typedef struct packed {
    seg_t hi;
    seg_t lo;
  } half_t;

  typedef struct {
    int nsegs;
    int exp_beats;
    int exp_rem_pops;
  } vec_t;

  logic            clk;
  logic            rst;
  logic [2*DW-1:0] fst_tdata, snd_tdata;
  logic [2*UW-1:0] fst_tuser, snd_tuser;
  logic [2*KW-1:0] fst_tkeep, snd_tkeep;
  logic [1:0]      fst_tlast, snd_tlast;
  logic            fst_empty, snd_empty, fst_rd_en, snd_rd_en;
  logic [DW-1:0]   rem_tdata;
  logic [UW-1:0]   rem_tuser;
  logic [KW-1:0]   rem_tkeep;
  logic            rem_tlast, rem_empty, rem_rd_en;
  logic [DW-1:0]   m_axis_tdata;
  logic [UW-1:0]   m_axis_tuser;
  logic [KW-1:0]   m_axis_tkeep;
  logic            m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic [31:0]     pkt_cnt;

  depar_seg_merge #(
    .C_AXIS_DATA_WIDTH (DW),
    .C_AXIS_TUSER_WIDTH(UW),
    .C_NUM_SEGS        (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fst_tdata    (fst_tdata),
    .fst_tuser    (fst_tuser),
    .fst_tkeep    (fst_tkeep),
    .fst_tlast    (fst_tlast),
    .fst_empty    (fst_empty),
    .fst_rd_en    (fst_rd_en),
    .snd_tdata    (snd_tdata),
    .snd_tuser    (snd_tuser),
    .snd_tkeep    (snd_tkeep),
    .snd_tlast    (snd_tlast),
    .snd_empty    (snd_empty),
    .snd_rd_en    (snd_rd_en),
    .rem_tdata    (rem_tdata),
    .rem_tuser    (rem_tuser),
    .rem_tkeep    (rem_tkeep),
    .rem_tlast    (rem_tlast),
    .rem_empty    (rem_empty),
    .rem_rd_en    (rem_rd_en),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .pkt_cnt      (pkt_cnt)
  );

  half_t  fst_q[$];
  half_t  snd_q[$];
  seg_t   rem_q[$];
  seg_t   exp_q[$];
  vec_t   tbl[7];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_fst = 0, n_snd = 0, n_rem = 0, n_beats = 0;
  int          cyc = 0, pop_cyc = 0, lat = -1;
  logic [31:0] exp_pkt_cnt = '0;
  logic        pend_half = 1'b0, pend_rem = 1'b0;
  logic        hold_rem = 1'b0, rand_ready = 1'b0;
  logic        prev_stall = 1'b0, prev_valid = 1'b0;
  seg_t        prev_beat;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic seg_t rand_seg(input logic last);
    seg_t s;
    for (int i = 0; i < DW / 32; i++) s.data[i*32 +: 32] = $urandom();
    for (int i = 0; i < UW / 32; i++) s.user[i*32 +: 32] = $urandom();
    s.keep = $urandom();
    s.last = last;
    return s;
  endfunction

  task automatic send_pkt(input int n);
    seg_t s[$];
    for (int i = 0; i < n; i++) begin
      s.push_back(rand_seg(i == n - 1));
      exp_q.push_back(s[i]);
    end
    while (s.size() < 4) s.push_back(rand_seg(1'($urandom_range(0, 1))));
    fst_q.push_back({s[1], s[0]});
    snd_q.push_back({s[3], s[2]});
    for (int i = 4; i < n; i++) rem_q.push_back(s[i]);
    exp_pkt_cnt = exp_pkt_cnt + 32'd1;
  endtask

  task automatic drive_heads();
    half_t h;
    seg_t  r;
    fst_empty = (fst_q.size() == 0);
    h = fst_empty ? '0 : fst_q[0];
    fst_tdata = {h.hi.data, h.lo.data};
    fst_tuser = {h.hi.user, h.lo.user};
    fst_tkeep = {h.hi.keep, h.lo.keep};
    fst_tlast = {h.hi.last, h.lo.last};
    snd_empty = (snd_q.size() == 0);
    h = snd_empty ? '0 : snd_q[0];
    snd_tdata = {h.hi.data, h.lo.data};
    snd_tuser = {h.hi.user, h.lo.user};
    snd_tkeep = {h.hi.keep, h.lo.keep};
    snd_tlast = {h.hi.last, h.lo.last};
    rem_empty = hold_rem || (rem_q.size() == 0);
    r = (rem_q.size() == 0) ? '0 : rem_q[0];
    rem_tdata = r.data;
    rem_tuser = r.user;
    rem_tkeep = r.keep;
    rem_tlast = r.last;
  endtask

  // FIFO model: apply the pops the DUT committed at this edge, then present new heads.
  initial forever begin
    @(posedge clk);
    #1;
    if (pend_half && fst_q.size() > 0) void'(fst_q.pop_front());
    if (pend_half && snd_q.size() > 0) void'(snd_q.pop_front());
    if (pend_rem && rem_q.size() > 0) void'(rem_q.pop_front());
    pend_half = 1'b0;
    pend_rem  = 1'b0;
    drive_heads();
    m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor on the falling edge: pops, handshakes and stall stability.
  initial forever begin
    seg_t cur, e;
    @(negedge clk);
    if (rst) begin
      chk("no_pop_in_reset", 512'({fst_rd_en, snd_rd_en, rem_rd_en}), 512'(0));
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (fst_rd_en || snd_rd_en) begin
        chk("half_pop", 512'({fst_rd_en, snd_rd_en, fst_empty, snd_empty}), 512'(4'b1100));
        pend_half = 1'b1;
        pop_cyc   = cyc;
      end
      if (fst_rd_en) n_fst++;
      if (snd_rd_en) n_snd++;
      if (rem_rd_en) begin
        chk("rem_pop_nonempty", 512'(rem_empty), 512'(0));
        pend_rem = 1'b1;
        n_rem++;
      end
      cur.data = m_axis_tdata;
      cur.user = m_axis_tuser;
      cur.keep = m_axis_tkeep;
      cur.last = m_axis_tlast;
      if (prev_stall) chk("hold_stable", 512'({m_axis_tvalid, cur}), 512'({1'b1, prev_beat}));
      if (m_axis_tvalid && !prev_valid) lat = cyc - pop_cyc;
      if (m_axis_tvalid && m_axis_tready) begin
        n_beats++;
        if (exp_q.size() == 0) begin
          chk("extra_beat", 512'(cur), 512'(0));
        end else begin
          e = exp_q.pop_front();
          chk("beat", 512'(cur), 512'(e));
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_valid = m_axis_tvalid;
      prev_beat  = cur;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || fst_q.size() != 0 || snd_q.size() != 0 || rem_q.size() != 0)
           && c < budget) begin
      tick();
      c++;
    end
    chk("drain_in_time", 512'(c >= budget), 512'(0));
    repeat (3) tick();
  endtask

  initial begin
    int b_fst, b_snd, b_rem, b_beats, c;
    rst = 1'b1;
    m_axis_tready = 1'b1;
    drive_heads();
    tbl[0] = '{1, 1, 0};
    tbl[1] = '{2, 2, 0};
    tbl[2] = '{3, 3, 0};
    tbl[3] = '{4, 4, 0};
    tbl[4] = '{5, 5, 1};
    tbl[5] = '{6, 6, 2};
    tbl[6] = '{8, 8, 4};

    repeat (3) tick();
    chk("rst_tvalid", 512'(m_axis_tvalid), 512'(0));
    chk("rst_tlast", 512'(m_axis_tlast), 512'(0));
    chk("rst_tdata", 512'(m_axis_tdata), 512'(0));
    chk("rst_pkt_cnt", 512'(pkt_cnt), 512'(0));
    rst = 1'b0;
    repeat (2) tick();

    // Table of packet lengths, full-rate sink.
    for (int i = 0; i < 7; i++) begin
      b_fst = n_fst; b_snd = n_snd; b_rem = n_rem; b_beats = n_beats;
      lat = -1;
      send_pkt(tbl[i].nsegs);
      wait_drain(200);
      chk("tbl_fst_pops", 512'(n_fst - b_fst), 512'(1));
      chk("tbl_snd_pops", 512'(n_snd - b_snd), 512'(1));
      chk("tbl_rem_pops", 512'(n_rem - b_rem), 512'(tbl[i].exp_rem_pops));
      chk("tbl_beats", 512'(n_beats - b_beats), 512'(tbl[i].exp_beats));
      chk("tbl_latency", 512'(lat), 512'(2));
      chk("tbl_pkt_cnt", 512'(pkt_cnt), 512'(exp_pkt_cnt));
    end

    // Six segments with the rem FIFO held empty: output must go idle.
    b_rem = n_rem; b_beats = n_beats;
    hold_rem = 1'b1;
    send_pkt(6);
    c = 0;
    while (exp_q.size() > 2 && c < 100) begin
      tick();
      c++;
    end
    chk("stall_reach", 512'(c >= 100), 512'(0));
    for (int i = 0; i < 5; i++) begin
      chk("stall_tvalid", 512'(m_axis_tvalid), 512'(0));
      chk("stall_rem_rd", 512'(rem_rd_en), 512'(0));
      tick();
    end
    hold_rem = 1'b0;
    wait_drain(200);
    chk("stall_rem_pops", 512'(n_rem - b_rem), 512'(2));
    chk("stall_beats", 512'(n_beats - b_beats), 512'(6));
    chk("stall_pkt_cnt", 512'(pkt_cnt), 512'(exp_pkt_cnt));

    // Ten back-to-back four-segment packets under random backpressure.
    b_beats = n_beats;
    rand_ready = 1'b1;
    for (int i = 0; i < 10; i++) send_pkt(4);
    wait_drain(2000);
    rand_ready = 1'b0;
    repeat (2) tick();
    chk("bp_beats", 512'(n_beats - b_beats), 512'(40));
    chk("bp_pkt_cnt", 512'(pkt_cnt), 512'(exp_pkt_cnt));

    // Reset after the second beat of a six-segment packet.
    send_pkt(6);
    c = 0;
    while (exp_q.size() > 4 && c < 100) begin
      tick();
      c++;
    end
    chk("mid_reach", 512'(c >= 100), 512'(0));
    rst = 1'b1;
    tick();
    chk("mid_rst_tvalid", 512'(m_axis_tvalid), 512'(0));
    chk("mid_rst_pkt_cnt", 512'(pkt_cnt), 512'(0));
    fst_q.delete();
    snd_q.delete();
    rem_q.delete();
    exp_q.delete();
    exp_pkt_cnt = '0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    b_beats = n_beats; b_rem = n_rem;
    send_pkt(3);
    wait_drain(200);
    chk("post_rst_beats", 512'(n_beats - b_beats), 512'(3));
    chk("post_rst_rem", 512'(n_rem - b_rem), 512'(0));
    chk("post_rst_pkt_cnt", 512'(pkt_cnt), 512'(1));

    // Counter wrap.
    force dut.r_pkt_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_pkt_cnt;
    tick();
    chk("wrap_preset", 512'(pkt_cnt), 512'(32'hFFFF_FFFF));
    exp_pkt_cnt = 32'hFFFF_FFFF;
    send_pkt(1);
    wait_drain(200);
    chk("wrap_pkt_cnt", 512'(pkt_cnt), 512'(32'h0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
